fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/cpu_pkg.sv | 14 +
 rtl/fetch_hold_buf.sv | 34 +++
 rtl/fetch_stage.sv | 139 +++++++++++++
 tb/tb_fetch_stage.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU types and constants.
// Contents: INSTR_W (instruction width), NOP (all-zero encoding),
//           OPC_MSB/OPC_LSB (opcode field position), fetchState_t (fetch FSM states),
//           opcodeOf() helper that extracts the opcode field.
package cpu_pkg;
    localparam int INSTR_W = 16;
    localparam logic [INSTR_W-1:0] NOP = '0;
    localparam int OPC_MSB = INSTR_W - 1;
    localparam int OPC_LSB = INSTR_W - 4;
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} fetchState_t;
    function automatic logic [OPC_MSB-OPC_LSB:0] opcodeOf(input logic [INSTR_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction
endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: one-entry buffer parking a fetched word while decode is stalled.
// Ports: clk, reset (sync, active-high); load/unload/clear controls (clear wins over load);
//        dataIn/pcIn captured on load; data/pc/full present the parked entry.
module fetch_hold_buf
    import cpu_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = cpu_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               unload,
    input  logic               clear,
    input  logic [INSTR_W-1:0] dataIn,
    input  logic [PC_W-1:0]    pcIn,
    output logic [INSTR_W-1:0] data,
    output logic [PC_W-1:0]    pc,
    output logic               full
);
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            data <= INSTR_W'(NOP);
            pc   <= '0;
            full <= 1'b0;
        end else if (load) begin
            data <= dataIn;
            pc   <= pcIn;
            full <= 1'b1;
        end else if (unload) begin
            full <= 1'b0;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch FSM, pc and IF/ID pipeline register.
// Ports: clk, reset (sync, active-high);
//        imem_req/imem_addr out, imem_valid/imem_rdata in (instruction memory);
//        stallD, branchD, flushD, branch_targetD in (decode-stage control);
//        instrD, pcD, validD out (IF/ID contents).
// Optional: define FETCH_PERF_EN to add fetch_cnt and bubble_cnt saturating counters.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = cpu_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stallD,
    input  logic               branchD,
    input  logic               flushD,
    input  logic [PC_W-1:0]    branch_targetD,
    output logic [INSTR_W-1:0] instrD,
    output logic [PC_W-1:0]    pcD,
`ifdef FETCH_PERF_EN
    output logic [15:0]        fetch_cnt,
    output logic [15:0]        bubble_cnt,
`endif
    output logic               validD
);
    fetchState_t        state, nextState;
    logic [PC_W-1:0]    pc, pcNext, dropAddr;
    logic [INSTR_W-1:0] hbData;
    logic [PC_W-1:0]    hbPc;
    logic               hbFull, hbLoad, hbUnload, hbClear, loadFromMem, wrIfId;
    logic               br, take;

    assign br     = branchD && !stallD;
    // flush also blocks loading so a fetched word parks in the hold buffer instead of being lost
    assign take   = !stallD && !flushD;
    assign wrIfId = loadFromMem || hbUnload;
    // DROP keeps presenting the address of the abandoned request until its response returns
    assign imem_addr = (state == DROP) ? dropAddr : pc;

    always_comb begin
        nextState   = state;
        pcNext      = pc;
        imem_req    = 1'b0;
        hbLoad      = 1'b0;
        hbUnload    = 1'b0;
        hbClear     = 1'b0;
        loadFromMem = 1'b0;
        case (state)
            IDLE: begin
                nextState = FETCH;
                pcNext    = br ? branch_targetD : pc;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (br) begin
                    pcNext    = branch_targetD;
                    hbClear   = 1'b1;
                    nextState = imem_valid ? FETCH : DROP;
                end else if (imem_valid) begin
                    pcNext      = pc + PC_W'(1);
                    loadFromMem = take;
                    hbLoad      = !take;
                    nextState   = take ? FETCH : HOLD;
                end
            end
            HOLD: begin
                if (br) begin
                    pcNext    = branch_targetD;
                    hbClear   = 1'b1;
                    nextState = FETCH;
                end else if (take && hbFull) begin
                    hbUnload  = 1'b1;
                    nextState = FETCH;
                end
            end
            default: begin
                imem_req  = 1'b1;
                pcNext    = br ? branch_targetD : pc;
                nextState = imem_valid ? FETCH : DROP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= '0;
            dropAddr <= '0;
            instrD   <= INSTR_W'(NOP);
            pcD      <= '0;
            validD   <= 1'b0;
        end else begin
            state    <= nextState;
            pc       <= pcNext;
            dropAddr <= (state == DROP) ? dropAddr : pc;
            if (flushD) begin
                instrD <= INSTR_W'(NOP);
                validD <= 1'b0;
            end else if (wrIfId) begin
                instrD <= loadFromMem ? imem_rdata : hbData;
                pcD    <= loadFromMem ? pc : hbPc;
                validD <= 1'b1;
            end else if (!stallD) begin
                instrD <= INSTR_W'(NOP);
                validD <= 1'b0;
            end
        end
    end

    fetch_hold_buf #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_holdBuf (
        .clk    (clk),
        .reset  (reset),
        .load   (hbLoad),
        .unload (hbUnload),
        .clear  (hbClear),
        .dataIn (imem_rdata),
        .pcIn   (pc),
        .data   (hbData),
        .pc     (hbPc),
        .full   (hbFull)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            fetch_cnt  <= fetch_cnt + 16'(wrIfId && fetch_cnt != 16'hFFFF);
            bubble_cnt <= bubble_cnt + 16'(!validD && !stallD && bubble_cnt != 16'hFFFF);
        end
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage.
// Memory is either zero-latency (returns 16'h1000+addr) or driven step by step.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset, imem_req, imem_valid, stallD, branchD, flushD, validD;
    logic [7:0]  imem_addr, branch_targetD, pcD;
    logic [15:0] imem_rdata, instrD, mData;
    logic        zl, mValid;
    int          total = 0;
    int          bad = 0;
`ifdef FETCH_PERF_EN
    logic [15:0] fetch_cnt, bubble_cnt;
`endif

    always #5 clk = ~clk;

    assign imem_valid = zl ? imem_req : mValid;
    assign imem_rdata = zl ? 16'h1000 + 16'(imem_addr) : mData;

    fetch_stage #(.PC_W(8), .INSTR_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_valid     (imem_valid),
        .imem_rdata     (imem_rdata),
        .stallD         (stallD),
        .branchD        (branchD),
        .flushD         (flushD),
        .branch_targetD (branch_targetD),
        .instrD         (instrD),
        .pcD            (pcD),
`ifdef FETCH_PERF_EN
        .fetch_cnt      (fetch_cnt),
        .bubble_cnt     (bubble_cnt),
`endif
        .validD         (validD)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; stallD = 1'b0; branchD = 1'b0; flushD = 1'b0;
        branch_targetD = 8'h00; zl = 1'b0; mValid = 1'b0; mData = 16'h0000;
        step();
        step();
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_instr", 32'(instrD), 32'h0);
        chk("rst_pcD", 32'(pcD), 32'h0);
        chk("rst_valid", 32'(validD), 32'h0);
        // zero-latency stream
        reset = 1'b0; zl = 1'b1;
        step();
        chk("first_req", 32'(imem_req), 32'h1);
        chk("first_addr", 32'(imem_addr), 32'h0);
        step();
        chk("s0_instr", 32'(instrD), 32'h1000);
        chk("s0_pcD", 32'(pcD), 32'h0);
        chk("s0_valid", 32'(validD), 32'h1);
        step();
        chk("s1_instr", 32'(instrD), 32'h1001);
        chk("s1_pcD", 32'(pcD), 32'h1);
        step();
        chk("s2_instr", 32'(instrD), 32'h1002);
        chk("s2_pcD", 32'(pcD), 32'h2);
        chk("s2_addr", 32'(imem_addr), 32'h3);
`ifdef FETCH_PERF_EN
        chk("perf_fetch", 32'(fetch_cnt), 32'd3);
        chk("perf_bubble", 32'(bubble_cnt), 32'd2);
`endif
        // response for pc=3 arrives while decode stalls for 3 cycles
        stallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pcD", 32'(pcD), 32'h2);
            chk("stall_instr", 32'(instrD), 32'h1002);
            chk("stall_req", 32'(imem_req), 32'h0);
        end
        stallD = 1'b0;
        step();
        chk("unhold_pcD", 32'(pcD), 32'h3);
        chk("unhold_instr", 32'(instrD), 32'h1003);
        chk("unhold_addr", 32'(imem_addr), 32'h4);
        // 2-cycle latency memory, redirect while the request to 4 is in flight
        zl = 1'b0; branchD = 1'b1; branch_targetD = 8'h40;
        step();
        branchD = 1'b0;
        chk("drop_req", 32'(imem_req), 32'h1);
        chk("drop_addr", 32'(imem_addr), 32'h4);
        chk("drop_valid", 32'(validD), 32'h0);
        step();
        mValid = 1'b1; mData = 16'hBEEF;
        step();
        mValid = 1'b0;
        chk("redir_addr", 32'(imem_addr), 32'h40);
        chk("dropped_valid", 32'(validD), 32'h0);
        chk("dropped_instr", 32'(instrD), 32'h0);
        step();
        mValid = 1'b1; mData = 16'h5040;
        step();
        mValid = 1'b0;
        chk("br_pcD", 32'(pcD), 32'h40);
        chk("br_instr", 32'(instrD), 32'h5040);
        chk("br_addr", 32'(imem_addr), 32'h41);
        // redirect coinciding with a response: the response must not reach IF/ID
        branchD = 1'b1; branch_targetD = 8'h80; mValid = 1'b1; mData = 16'hDEAD;
        step();
        branchD = 1'b0;
        chk("coin_addr", 32'(imem_addr), 32'h80);
        chk("coin_valid", 32'(validD), 32'h0);
        chk("coin_instr", 32'(instrD), 32'h0);
        mData = 16'h6080;
        step();
        mValid = 1'b0;
        chk("pre_flush_instr", 32'(instrD), 32'h6080);
        // flush overrides stall
        stallD = 1'b1; flushD = 1'b1;
        step();
        stallD = 1'b0; flushD = 1'b0;
        chk("flush_valid", 32'(validD), 32'h0);
        chk("flush_instr", 32'(instrD), 32'h0);
        chk("flush_pcD", 32'(pcD), 32'h80);
        // pc wrap at 8'hFF
        branchD = 1'b1; branch_targetD = 8'hFF; mValid = 1'b1; mData = 16'h1111;
        step();
        branchD = 1'b0; mData = 16'h70FF;
        chk("wrap_addr_ff", 32'(imem_addr), 32'hFF);
        step();
        mValid = 1'b0;
        chk("wrap_pcD", 32'(pcD), 32'hFF);
        chk("wrap_addr", 32'(imem_addr), 32'h00);
        // reset mid-FETCH, late response lands in IDLE
        chk("pre_rst_req", 32'(imem_req), 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0; mValid = 1'b1; mData = 16'hABCD;
        chk("mrst_req", 32'(imem_req), 32'h0);
        chk("mrst_instr", 32'(instrD), 32'h0);
        chk("mrst_pcD", 32'(pcD), 32'h0);
        chk("mrst_valid", 32'(validD), 32'h0);
`ifdef FETCH_PERF_EN
        chk("mrst_fetch_cnt", 32'(fetch_cnt), 32'h0);
        chk("mrst_bubble_cnt", 32'(bubble_cnt), 32'h0);
`endif
        step();
        mValid = 1'b0;
        chk("ign_instr", 32'(instrD), 32'h0);
        chk("ign_valid", 32'(validD), 32'h0);
        chk("ign_req", 32'(imem_req), 32'h1);
        chk("ign_addr", 32'(imem_addr), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
